// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op and FSM encodings shared by the multiply/divide unit
package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_FIN  = 2'b11
   } state_t;

   function automatic logic op_is_div(input logic [1:0] o);
      return (o == OP_DIVU) || (o == OP_DIV);
   endfunction

   function automatic logic op_is_signed(input logic [1:0] o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MIPS-style HI/LO multiply/divide unit
// One shift-add or restoring subtract-shift step per cycle; HI/LO update on entry to FIN.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b, count;
   logic             neg_main, neg_rem, dbz;
   logic             is_div, is_signed, zero_div, last;
   logic [WIDTH-1:0] rs_mag, rt_mag;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [WIDTH-1:0] step_hi, step_lo, fin_hi, fin_lo;

   always_comb begin
      is_div    = op_is_div(op);
      is_signed = op_is_signed(op);
      zero_div  = is_div && (rt_val == '0);
      rs_mag    = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
      rt_mag    = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
      last      = (count == WIDTH'(WIDTH - 1));
   end

   // acc_hi is the partial product / remainder, acc_lo the multiplier / quotient shifter
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_b};
      step_hi   = mul_sum[WIDTH:1];
      step_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
      fin_hi    = '0;
      fin_lo    = '0;
      if (state == ST_DIV) begin
         if (!div_diff[WIDTH]) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
         fin_lo = neg_main ? -step_lo : step_lo;
         fin_hi = neg_rem  ? -step_hi : step_hi;
      end else begin
         {fin_hi, fin_lo} = neg_main ? -{step_hi, step_lo} : {step_hi, step_lo};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      busy        = 1'b0;
      done        = 1'b0;
      div_by_zero = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (!is_div)       state_nxt = ST_MUL;
               else if (zero_div) state_nxt = ST_FIN;
               else               state_nxt = ST_DIV;
            end
         end
         ST_MUL, ST_DIV: begin
            busy = 1'b1;
            if (last) state_nxt = ST_FIN;
         end
         default: begin
            done        = 1'b1;
            div_by_zero = dbz;
            state_nxt   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi       <= '0;
         lo       <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd_b   <= '0;
         count    <= '0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         dbz      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  acc_hi   <= '0;
                  acc_lo   <= is_div ? rs_mag : rt_mag;
                  opnd_b   <= is_div ? rt_mag : rs_mag;
                  count    <= '0;
                  neg_main <= is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                  neg_rem  <= is_signed && rs_val[WIDTH-1];
                  dbz      <= zero_div;
                  if (zero_div) begin
                     hi <= rs_val;
                     lo <= '1;
                  end
               end else begin
                  if (mthi) hi <= wdata;
                  if (mtlo) lo <= wdata;
               end
            end
            ST_MUL, ST_DIV: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               if (last) begin
                  count <= '0;
                  hi    <= fin_hi;
                  lo    <= fin_lo;
               end else begin
                  count <= count + WIDTH'(1);
               end
            end
            default: dbz <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst_n, start, mthi, mtlo;
   logic [1:0]  op;
   logic [31:0] rs_val, rt_val, wdata;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;
   int          n_checks = 0;
   int          n_fail = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00:   r = {32'h0, a} * {32'h0, b};
         2'b01:   r = 64'(sa * sb);
         2'b10:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      endcase
      return r;
   endfunction

   // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after done.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int inj,
                        output int done_cyc, output logic busy_ok, output logic hold_ok,
                        output logic dz, output logic [31:0] rh, output logic [31:0] rl);
      logic [31:0] h0, l0;
      op = o; rs_val = a; rt_val = b; start = 1'b1;
      h0 = hi; l0 = lo;
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
      done_cyc = -1; busy_ok = 1'b1; hold_ok = 1'b1; dz = 1'b0; rh = '0; rl = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done) begin
            done_cyc = c; dz = div_by_zero; rh = hi; rl = lo;
            if (busy) busy_ok = 1'b0;
            break;
         end
         if (!busy) busy_ok = 1'b0;
         if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
         if (c == inj) begin
            start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
         end else begin
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
         end
      end
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      op = 2'b00; rs_val = '0; rt_val = '0; wdata = '0;
      #1;
      n_checks++;
      if ({busy, done, div_by_zero} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: busy/done/dbz=%b expected 000", {busy, done, div_by_zero});
      end
      n_checks++;
      if ({hi, lo} !== 64'h0) begin
         n_fail++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mthi_mtlo;
      mthi = 1'b1; wdata = 32'h0000_1234;
      @(negedge clk); mthi = 1'b0;
      n_checks++;
      if (hi !== 32'h0000_1234 || lo !== 32'h0) begin
         n_fail++; $display("FAIL mthi_write: hi=%h lo=%h expected hi=00001234 lo=0", hi, lo);
      end
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_0F0F;
      @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
      n_checks++;
      if (hi !== 32'hA5A5_0F0F || lo !== 32'hA5A5_0F0F) begin
         n_fail++; $display("FAIL mthi_mtlo_both: hi=%h lo=%h expected a5a50f0f", hi, lo);
      end
   endtask

   task automatic test_directed;
      int dc; logic bo, ho, dz; logic [31:0] rh, rl;
      do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, dc, bo, ho, dz, rh, rl);
      n_checks++;
      if (dc !== 33 || !bo || !ho || dz !== 1'b0) begin
         n_fail++; $display("FAIL multu_timing: done_cycle=%0d busy_ok=%b hold_ok=%b dbz=%b expected 33/1/1/0", dc, bo, ho, dz);
      end
      n_checks++;
      if ({rh, rl} !== 64'hFFFF_FFFE_0000_0001) begin
         n_fail++; $display("FAIL multu_max: got %h expected fffffffe00000001", {rh, rl});
      end
      do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, dc, bo, ho, dz, rh, rl);
      n_checks++;
      if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
         n_fail++; $display("FAIL mult_neg3x7: got %h expected ffffffffffffffeb", {rh, rl});
      end
      do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, dc, bo, ho, dz, rh, rl);
      n_checks++;
      if (rl !== 32'hFFFF_FFFD || rh !== 32'hFFFF_FFFF || dc !== 33) begin
         n_fail++; $display("FAIL div_neg7by2: lo=%h hi=%h cyc=%0d expected fffffffd ffffffff 33", rl, rh, dc);
      end
      do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, dc, bo, ho, dz, rh, rl);
      n_checks++;
      if (rl !== 32'h8000_0000 || rh !== 32'h0 || dz !== 1'b0) begin
         n_fail++; $display("FAIL div_overflow: lo=%h hi=%h dbz=%b expected 80000000 0 0", rl, rh, dz);
      end
      do_op(2'b10, 32'd100, 32'd0, 0, dc, bo, ho, dz, rh, rl);
      n_checks++;
      if (dc !== 1 || dz !== 1'b1 || !bo) begin
         n_fail++; $display("FAIL divu_zero_timing: cyc=%0d dbz=%b busy_ok=%b expected 1 1 1", dc, dz, bo);
      end
      n_checks++;
      if (rl !== 32'hFFFF_FFFF || rh !== 32'd100) begin
         n_fail++; $display("FAIL divu_zero_value: lo=%h hi=%h expected ffffffff 00000064", rl, rh);
      end
   endtask

   task automatic test_ignore_writes;
      int dc; logic bo, ho, dz; logic [31:0] rh, rl;
      mthi = 1'b1; wdata = 32'h0000_5555;
      do_op(2'b00, 32'd5, 32'd3, 0, dc, bo, ho, dz, rh, rl);
      n_checks++;
      if (hi !== 32'h0 || lo !== 32'd15) begin
         n_fail++; $display("FAIL start_priority: hi=%h lo=%h expected 0 0000000f", hi, lo);
      end
      do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 5, dc, bo, ho, dz, rh, rl);
      n_checks++;
      if (dc !== 33 || {rh, rl} !== 64'hFFFF_FFFF_FFFF_FFEB || !bo || !ho) begin
         n_fail++; $display("FAIL midop_pulses: cyc=%0d result=%h busy_ok=%b hold_ok=%b expected 33 ffffffffffffffeb 1 1", dc, {rh, rl}, bo, ho);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || lo !== 32'hFFFF_FFEB) begin
         n_fail++; $display("FAIL midop_no_restart: busy=%b lo=%h expected 0 ffffffeb", busy, lo);
      end
   endtask

   task automatic test_reset_mid;
      int dc; logic bo, ho, dz; logic [31:0] rh, rl;
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
      @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
      op = 2'b10; rs_val = 32'd1000; rt_val = 32'd7; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (10) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL divu_busy_c10: busy=%b expected 1", busy);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, div_by_zero} !== 3'b000 || {hi, lo} !== 64'h0) begin
         n_fail++; $display("FAIL midop_reset: flags=%b hilo=%h expected 000 0", {busy, done, div_by_zero}, {hi, lo});
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(2'b00, 32'd6, 32'd7, 0, dc, bo, ho, dz, rh, rl);
      n_checks++;
      if (dc !== 33 || rl !== 32'd42 || rh !== 32'd0) begin
         n_fail++; $display("FAIL post_reset_start: cyc=%0d lo=%h hi=%h expected 33 0000002a 0", dc, rl, rh);
      end
   endtask

   task automatic test_back_to_back;
      int dc; logic bo, ho, dz; logic [31:0] rh, rl;
      do_op(2'b10, 32'd1_000_003, 32'd97, 0, dc, bo, ho, dz, rh, rl);
      do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, dc, bo, ho, dz, rh, rl);
      n_checks++;
      if (dc !== 33 || {rh, rl} !== 64'h4000_0000_0000_0000) begin
         n_fail++; $display("FAIL back_to_back: cyc=%0d result=%h expected 33 4000000000000000", dc, {rh, rl});
      end
   endtask

   task automatic test_random;
      int dc, exp_cyc; logic bo, ho, dz; logic [31:0] rh, rl, a, b; logic [1:0] o; logic [63:0] exp;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom; b = $urandom;
         case ($urandom_range(0, 7))
            0: b = '0;
            1: b = 32'($urandom_range(1, 20));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3: a = 32'($urandom_range(0, 1000));
            default: ;
         endcase
         exp = model(o, a, b);
         exp_cyc = (o[1] && b == 0) ? 1 : 33;
         do_op(o, a, b, 0, dc, bo, ho, dz, rh, rl);
         n_checks++;
         if ({rh, rl} !== exp || dc !== exp_cyc || dz !== (o[1] && b == 0) || !bo || !ho) begin
            n_fail++;
            $display("FAIL random_%0d op=%0d a=%h b=%h: got %h cyc=%0d dbz=%b busy_ok=%b hold_ok=%b expected %h cyc=%0d",
                     i, o, a, b, {rh, rl}, dc, dz, bo, ho, exp, exp_cyc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mthi_mtlo();
      test_directed();
      test_ignore_writes();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
